// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready handshake and shifts it
// out one bit per clock. Optional even-parity trailer bit enabled by macro PISO_PARITY_EN.
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_en,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    assign accept = load_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = load_data;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    // Counter holds at zero rather than wrapping; only accept reloads it.
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PISO_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^load_data;
        end
    end
`endif

    always_comb begin
        load_ready = (state_q == IDLE);
        ser_en     = 1'b0;
        ser_out    = IDLE_LEVEL;
        done       = 1'b0;
        case (state_q)
            SHIFT: begin
                ser_en  = 1'b1;
                ser_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`ifndef PISO_PARITY_EN
                done    = (cnt_q == '0);
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                ser_en  = 1'b1;
                ser_out = par_q;
                done    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
